// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, parity modes, frame-length bounds and parity helper for the UART transmitter.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BITS, CLEAN_UP} state_t;
    typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2} par_t;
    localparam logic [3:0] LEN_MIN = 4'd5;
    localparam logic [3:0] LEN_MAX = 4'd8;
    function automatic logic parity(logic [7:0] d, logic [3:0] len, logic odd);
        return odd ^ (^(d & (8'hFF >> (LEN_MAX - len))));
    endfunction
endpackage

// File: rtl/uart_trans_cfg_if.sv
// uart_trans_cfg_if: request/config inputs and serial/status outputs of the configurable UART transmitter.
interface uart_trans_cfg_if #(parameter int DATA_W = 8);
    logic              TX_DV;
    logic [DATA_W-1:0] TX_BYTE;
    logic [3:0]        CFG_LEN;
    logic [1:0]        CFG_PARITY;
    logic              CFG_STOP2;
    logic              TX_Ready;
    logic              TX_serial;
    logic              TX_Active;
    logic              TX_Done;
    modport master (output TX_DV, TX_BYTE, CFG_LEN, CFG_PARITY, CFG_STOP2,
                    input  TX_Ready, TX_serial, TX_Active, TX_Done);
    modport slave  (input  TX_DV, TX_BYTE, CFG_LEN, CFG_PARITY, CFG_STOP2,
                    output TX_Ready, TX_serial, TX_Active, TX_Done);
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter; pulses bit_end on the last cycle of each bit, cleared on state change.
module uart_baud_cnt #(parameter int CLKS_PER_BIT = 217) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    logic [W-1:0] cnt;
    assign bit_end = cnt == LAST;
    always_ff @(posedge clk)
        cnt <= (rst || clr || bit_end) ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_trans_cfg.sv
// uart_trans_cfg: UART transmitter with per-frame length, parity and stop-bit configuration.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_trans_cfg import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_W       = 8
) (
    input  logic clk,
    input  logic rst,
    uart_trans_cfg_if.slave bus
);
    localparam logic [3:0] LEN_HI = 4'(DATA_W);
    state_t     state, state_n;
    logic [2:0] idx, idx_n;
    logic       stop_cnt, stop_n, serial, serial_n;
    logic       bit_end, accept, par_en, par_val, stop2;
    logic [7:0] data;
    logic [3:0] len, cfg_len;
    assign accept  = state == IDLE && bus.TX_DV;
    assign cfg_len = bus.CFG_LEN < LEN_MIN ? LEN_MIN : bus.CFG_LEN > LEN_HI ? LEN_HI : bus.CFG_LEN;
`ifdef UART_TX_PARITY_EN
    logic [1:0] par_mode;
    always_ff @(posedge clk)
        if (accept && !rst) par_mode <= bus.CFG_PARITY;
    assign par_en  = par_mode == PAR_EVEN || par_mode == PAR_ODD;
    assign par_val = parity(data, len, par_mode == PAR_ODD);
`else
    assign par_en  = 1'b0;
    assign par_val = 1'b0;
`endif
    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk(clk), .rst(rst), .clr(state_n != state), .bit_end(bit_end)
    );
    always_comb begin
        state_n = state;
        idx_n   = idx;
        stop_n  = stop_cnt;
        case (state)
            IDLE:       state_n = bus.TX_DV ? START_BIT : IDLE;
            START_BIT:  if (bit_end) begin
                            state_n = DATA_BITS;
                            idx_n   = 3'd0;
                        end
            DATA_BITS:  if (bit_end) begin
                            if ({1'b0, idx} == len - 4'd1) begin
                                state_n = par_en ? PARITY_BIT : STOP_BITS;
                                stop_n  = 1'b0;
                            end else
                                idx_n = idx + 3'd1;
                        end
            PARITY_BIT: if (bit_end) begin
                            state_n = STOP_BITS;
                            stop_n  = 1'b0;
                        end
            STOP_BITS:  if (bit_end) begin
                            if (stop2 && !stop_cnt) stop_n = 1'b1;
                            else state_n = CLEAN_UP;
                        end
            CLEAN_UP:   state_n = IDLE;
            default:    state_n = IDLE;
        endcase
        // line is registered from the next state so the start bit appears one cycle after accept
        serial_n = state_n == START_BIT  ? 1'b0 :
                   state_n == DATA_BITS  ? data[idx_n] :
                   state_n == PARITY_BIT ? par_val : 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 3'd0;
            stop_cnt <= 1'b0;
            serial   <= 1'b1;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            stop_cnt <= stop_n;
            serial   <= serial_n;
        end
    end
    always_ff @(posedge clk)
        if (accept && !rst) begin
            data  <= 8'(bus.TX_BYTE);
            len   <= cfg_len;
            stop2 <= bus.CFG_STOP2;
        end
    assign bus.TX_Ready  = state == IDLE;
    assign bus.TX_serial = serial;
    assign bus.TX_Active = state inside {START_BIT, DATA_BITS, PARITY_BIT, STOP_BITS};
    assign bus.TX_Done   = state == CLEAN_UP;
endmodule
